// File: rtl/frame_sender.sv
`default_nettype none
// ============================================================================
//  Module   : frame_sender
//  Purpose  : Buffers an upstream payload into a FIFO, then emits it as a
//             frame followed by a terminator byte, with an XOR checksum of
//             the payload on crc_out. Payload bytes equal to the terminator
//             are dropped; a FIFO that fills without s_last auto-closes.
//  Revision : 1.0 - initial release
// ============================================================================
module frame_sender #(
    parameter int         FIFO_DEPTH = 16,
    parameter logic [7:0] TERM_BYTE  = 8'h10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic [7:0] frame_data,
    output logic       frame_valid,
    input  logic       frame_ready,
    output logic [7:0] crc_out,
    output logic       frame_done,
    output logic       illegal_byte,
    output logic       truncated
);

    localparam int            c_ADDR_W = $clog2(FIFO_DEPTH);
    localparam logic [c_ADDR_W:0] c_FULL = (c_ADDR_W + 1)'(FIFO_DEPTH);
    localparam logic [c_ADDR_W:0] c_ONE  = (c_ADDR_W + 1)'(1);

    typedef enum logic [1:0] {
        FILL = 2'd0,
        SEND = 2'd1,
        TERM = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [c_ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_ADDR_W:0]   count_q, count_d;
    logic [7:0]          acc_q, acc_d;
    logic [7:0]          crc_q, crc_d;
    logic                illegal_q, illegal_d;
    logic                trunc_q, trunc_d;
    logic [7:0]          mem_q [FIFO_DEPTH];
    logic                w_push;
    logic [7:0]          w_head;

    assign w_head       = mem_q[rd_ptr_q];
    assign crc_out      = crc_q;
    assign illegal_byte = illegal_q;
    assign truncated    = trunc_q;

    // Next-state, FIFO bookkeeping and frame outputs; frame outputs decode
    // from state so an asynchronous reset clears them immediately.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        acc_d       = acc_q;
        crc_d       = crc_q;
        illegal_d   = 1'b0;
        trunc_d     = 1'b0;
        w_push      = 1'b0;
        s_ready     = 1'b0;
        frame_valid = 1'b0;
        frame_data  = 8'h00;
        frame_done  = 1'b0;
        case (state_q)
            FILL: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    if (s_data != TERM_BYTE) begin
                        w_push   = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        count_d  = count_q + 1'b1;
                    end else begin
                        illegal_d = 1'b1;
                    end
                    if (s_last) begin
                        acc_d = 8'h00;
                        if (count_d == '0) begin
                            // Empty frame: only the terminator goes out.
                            state_d = TERM;
                            crc_d   = 8'h00;
                        end else begin
                            state_d = SEND;
                        end
                    end else if (w_push && count_d == c_FULL) begin
                        state_d = SEND;
                        acc_d   = 8'h00;
                        trunc_d = 1'b1;
                    end
                end
            end
            SEND: begin
                frame_valid = 1'b1;
                frame_data  = w_head;
                if (frame_ready) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    count_d  = count_q - 1'b1;
                    acc_d    = acc_q ^ w_head;
                    if (count_q == c_ONE) begin
                        // Checksum published on the edge that presents TERM.
                        state_d = TERM;
                        crc_d   = acc_q ^ w_head;
                    end
                end
            end
            TERM: begin
                frame_valid = 1'b1;
                frame_data  = TERM_BYTE;
                if (frame_ready) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                frame_done = 1'b1;
                state_d    = FILL;
                wr_ptr_d   = '0;
                rd_ptr_d   = '0;
                count_d    = '0;
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    // Control state register with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= FILL;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            acc_q     <= 8'h00;
            crc_q     <= 8'h00;
            illegal_q <= 1'b0;
            trunc_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            acc_q     <= acc_d;
            crc_q     <= crc_d;
            illegal_q <= illegal_d;
            trunc_q   <= trunc_d;
        end
    end

    // Payload storage; contents are don't-care while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= s_data;
        end
    end

endmodule
`default_nettype wire
